// File: rtl/gfx_pkg.sv
// rtl/gfx_pkg.sv - shared types and default constants for the line render scheduler
// Purpose: scheduler FSM state encoding, tilemap index type, VGA timing defaults.
// Ports: none (package).
package gfx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_T_GO   = 3'd1,
    ST_T_ARM  = 3'd2,
    ST_T_WAIT = 3'd3,
    ST_S_GO   = 3'd4,
    ST_S_ARM  = 3'd5,
    ST_S_WAIT = 3'd6
  } sched_state_t;

  typedef logic [1:0] tilemap_idx_t;

  localparam int H_TRIGGER_DEF = 0;
  localparam int V_ACTIVE_DEF  = 480;
  localparam int V_LAST_DEF    = 524;
  localparam int CNT_W_DEF     = 8;

endpackage

// File: rtl/line_render_scheduler_trig.sv
// rtl/line_render_scheduler_trig.sv - once-per-line trigger from a registered hcount match
// Purpose: raise o_trig for exactly one cycle on the first registered match of
//          i_hcount == H_TRIGGER, so a stalled hcount yields a single trigger.
// Ports:
//   i_clk, i_reset  clock, synchronous active-low reset
//   i_hcount        VGA horizontal counter
//   o_trig          one-cycle trigger pulse
module line_render_scheduler_trig #(
  parameter logic [10:0] H_TRIGGER = 11'd0
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [10:0] i_hcount,
  output logic        o_trig
);

  logic r_match;
  logic r_match_d;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_match   <= 1'b0;
      r_match_d <= 1'b0;
    end else begin
      r_match   <= (i_hcount == H_TRIGGER);
      r_match_d <= r_match;
    end
  end

  assign o_trig = r_match & ~r_match_d;

endmodule

// File: rtl/line_render_scheduler.sv
// rtl/line_render_scheduler.sv - per-scanline tile/sprite render sequencer
// Purpose: on each line trigger pulse the tile engine, wait for done, pulse the
//          sprite engine, wait for done. Owns the ping-pong line buffer select,
//          shadows the tilemap index to frame boundaries, counts overruns.
// Ports:
//   i_clk, i_reset          clock, synchronous active-low reset
//   i_hcount, i_vcount      VGA timing counters
//   i_cfg_tilemap_idx       requested tilemap; i_cfg_wr latches it into pending
//   o_tile_start/i_tile_done  tile engine handshake; o_tilemap_idx shadowed index
//   o_spr_start/i_spr_done    sprite engine handshake
//   o_wbuf_sel/o_rbuf_sel   line buffer write/display selects (always complementary)
//   o_line_ready            render complete until next trigger
//   o_overrun/o_overrun_cnt sticky overrun flag and saturating count
module line_render_scheduler
  import gfx_pkg::*;
#(
  parameter int H_TRIGGER = H_TRIGGER_DEF,
  parameter int V_ACTIVE  = V_ACTIVE_DEF,
  parameter int V_LAST    = V_LAST_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [10:0]        i_hcount,
  input  logic [9:0]         i_vcount,
  input  tilemap_idx_t       i_cfg_tilemap_idx,
  input  logic               i_cfg_wr,
  output logic               o_tile_start,
  output tilemap_idx_t       o_tilemap_idx,
  input  logic               i_tile_done,
  output logic               o_spr_start,
  input  logic               i_spr_done,
  output logic               o_wbuf_sel,
  output logic               o_rbuf_sel,
  output logic               o_line_ready,
  output logic               o_overrun,
  output logic [CNT_W-1:0]   o_overrun_cnt
);

  sched_state_t     r_state;
  sched_state_t     w_state_next;
  logic             w_trig;
  logic             w_render_line;
  logic             w_toggle_line;
  logic             w_last_line;
  logic             w_line_done;
  logic             w_overrun_evt;
  logic             r_wbuf_sel;
  logic             r_line_ready;
  logic             r_overrun;
  logic [CNT_W-1:0] r_overrun_cnt;
  tilemap_idx_t     r_tilemap_idx;
  tilemap_idx_t     r_pending;

  line_render_scheduler_trig #(
    .H_TRIGGER (11'(H_TRIGGER))
  ) u_trig (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_hcount (i_hcount),
    .o_trig   (w_trig)
  );

  // Lines 0..V_ACTIVE-2 render the next visible line; the last frame line renders line 0.
  // The final visible line still flips buffers so its own render gets displayed.
  assign w_last_line   = (i_vcount == 10'(V_LAST));
  assign w_render_line = (i_vcount <= 10'(V_ACTIVE - 2)) || w_last_line;
  assign w_toggle_line = w_render_line || (i_vcount == 10'(V_ACTIVE - 1));
  assign w_overrun_evt = w_trig && (r_state != ST_IDLE);

  always_comb begin
    w_state_next = r_state;
    w_line_done  = 1'b0;
    o_tile_start = 1'b0;
    o_spr_start  = 1'b0;
    case (r_state)
      ST_T_GO: o_tile_start = 1'b1;
      ST_S_GO: o_spr_start  = 1'b1;
      default: ;
    endcase
    if (w_trig) begin
      // A trigger always wins: a busy FSM is restarted (or parked) rather than finishing late.
      w_state_next = w_render_line ? ST_T_GO : ST_IDLE;
    end else begin
      case (r_state)
        ST_T_GO:   w_state_next = ST_T_ARM;
        // Guard cycle: the engine's done is still stale-high from the previous line.
        ST_T_ARM:  w_state_next = ST_T_WAIT;
        ST_T_WAIT: if (i_tile_done) w_state_next = ST_S_GO;
        ST_S_GO:   w_state_next = ST_S_ARM;
        ST_S_ARM:  w_state_next = ST_S_WAIT;
        ST_S_WAIT: begin
          if (i_spr_done) begin
            w_state_next = ST_IDLE;
            w_line_done  = 1'b1;
          end
        end
        default:   w_state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state       <= ST_IDLE;
      r_wbuf_sel    <= 1'b0;
      r_line_ready  <= 1'b0;
      r_overrun     <= 1'b0;
      r_overrun_cnt <= '0;
      r_tilemap_idx <= '0;
      r_pending     <= '0;
    end else begin
      r_state <= w_state_next;
      if (i_cfg_wr) r_pending <= i_cfg_tilemap_idx;
      // Old pending is taken here, so a same-cycle cfg_wr lands in the following frame.
      if (w_trig && w_last_line) r_tilemap_idx <= r_pending;
      if (w_trig && w_toggle_line) begin
        r_wbuf_sel   <= ~r_wbuf_sel;
        r_line_ready <= 1'b0;
      end else if (w_line_done) begin
        r_line_ready <= 1'b1;
      end
      if (w_overrun_evt) begin
        r_overrun <= 1'b1;
        if (r_overrun_cnt != '1) r_overrun_cnt <= r_overrun_cnt + CNT_W'(1);
      end
    end
  end

  assign o_wbuf_sel    = r_wbuf_sel;
  assign o_rbuf_sel    = ~r_wbuf_sel;
  assign o_line_ready  = r_line_ready;
  assign o_overrun     = r_overrun;
  assign o_overrun_cnt = r_overrun_cnt;
  assign o_tilemap_idx = r_tilemap_idx;

endmodule
